// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1001 detector slice and its serial feeder.
// The counter-width helper lets parameterised modules size their bit counters consistently.
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int         DEFAULT_WIDTH = 8;
  localparam int         CNT_W         = $clog2(DEFAULT_WIDTH);
  localparam logic [3:0] PATTERN_1001  = 4'b1001;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 1001 detector: first bit one cycle after accept, one bit per clock.
// Backpressure: load_ready drops only while the one-word pending buffer is full; the serial side never stalls.
module seq_bit_serializer
  import seq_det_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             x_out,
  output logic             x_valid,
  output logic             x_last,
  output logic             busy
);

  localparam int            CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             last_bit;

  assign accept   = load_valid && load_ready;
  assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
  assign shifted  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_bit && !pend_vld_q && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Last-bit edge reloads from pending first, then from a same-edge accept (bypass), else drains.
  always_comb begin
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (state_q == IDLE) begin
      if (accept) begin
        shreg_d = load_data;
        cnt_d   = CNT_MAX;
      end
    end else if (last_bit) begin
      if (pend_vld_q) begin
        shreg_d    = pend_q;
        cnt_d      = CNT_MAX;
        pend_vld_d = 1'b0;
      end else if (accept) begin
        shreg_d = load_data;
        cnt_d   = CNT_MAX;
      end else begin
        shreg_d = '0;
        cnt_d   = '0;
      end
    end else begin
      shreg_d = shifted;
      cnt_d   = cnt_q - CW'(1);
      if (accept) begin
        pend_d     = load_data;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  always_comb begin
    load_ready = (state_q == IDLE) || !pend_vld_q;
    x_valid    = (state_q == SHIFT);
    x_last     = last_bit;
    busy       = (state_q == SHIFT) || pend_vld_q;
    x_out      = IDLE_BIT;
    if (state_q == SHIFT) x_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  end

endmodule
